cache_fill_ctrl: RTL and testbench

Parametrised miss-handling controller shared by the instruction and data caches of the five-stage pipeline. On a cache miss it stalls the pipeline and, when write-back is compiled in, first writes a dirty victim line back to memory. It then issues one read per word of the missing line to the pipelined memory and steers each returned word into the cache data array. It writes the tag once the whole line has been filled.

---
 rtl/cache_fill_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: optional dirty-victim write-back, then line fill.
// Write-back path is built only when CACHE_FILL_WRITEBACK_EN is defined.
module cache_fill_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_detected,
    input  logic [ADDR_W-1:0]                 miss_address,
    input  logic                              victim_dirty,
    input  logic [ADDR_W-1:0]                 victim_address,
    input  logic [DATA_W-1:0]                 evict_data,
    input  logic                              memory_data_valid,
    output logic                              fsm_busy,
    output logic                              write_data_array,
    output logic                              write_tag_array,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
    output logic                              mem_enable,
    output logic                              mem_wr,
    output logic [ADDR_W-1:0]                 memory_address,
    output logic [DATA_W-1:0]                 mem_wdata
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = $clog2(WORDS_PER_LINE * BPW);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  N_WORDS  = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] miss_base;
    logic              issue_more;
    logic              ret_take;
    logic              last_ret;
    logic              dirty_miss;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CNT_W-1:0]  idx
    );
        return base + ADDR_W'(idx) * ADDR_W'(BPW);
    endfunction

    assign miss_base  = miss_address & ~OFF_MASK;
    assign issue_more = (issue_cnt < N_WORDS);
    assign ret_take   = (state == FILL) && memory_data_valid
                        && (ret_cnt < N_WORDS);
    assign last_ret   = ret_take && (ret_cnt == N_WORDS - CNT_ONE);

`ifdef CACHE_FILL_WRITEBACK_EN
    logic [ADDR_W-1:0] victim_base;

    assign dirty_miss = victim_dirty;

    // Victim line base is captured with the miss so the bus value may change.
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_base <= '0;
        end else if (state == IDLE && miss_detected) begin
            victim_base <= victim_address & ~OFF_MASK;
        end
    end
`else
    logic unused_victim;

    assign dirty_miss    = 1'b0;
    assign unused_victim = ^{victim_dirty, victim_address, evict_data};
`endif

    // State, counters and line base; counters saturate at WORDS_PER_LINE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            line_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        line_base <= miss_base;
                        ret_cnt   <= '0;
                        if (dirty_miss) begin
                            issue_cnt <= '0;
                            state     <= EVICT;
                        end else begin
                            issue_cnt <= CNT_ONE;
                            state     <= FILL;
                        end
                    end
                end
`ifdef CACHE_FILL_WRITEBACK_EN
                EVICT: begin
                    if (issue_cnt == N_WORDS - CNT_ONE) begin
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= FILL;
                    end else begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                    end
                end
`endif
                FILL: begin
                    if (issue_more) issue_cnt <= issue_cnt + CNT_ONE;
                    if (ret_take) ret_cnt <= ret_cnt + CNT_ONE;
                    if (last_ret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and array controls; the miss cycle itself already stalls and issues.
    always_comb begin
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word        = '0;
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        memory_address   = '0;
        mem_wdata        = '0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    fsm_busy = 1'b1;
                    if (!dirty_miss) begin
                        mem_enable     = 1'b1;
                        memory_address = miss_base;
                    end
                end
            end
`ifdef CACHE_FILL_WRITEBACK_EN
            EVICT: begin
                fsm_busy       = 1'b1;
                fill_word      = issue_cnt[IDX_W-1:0];
                mem_enable     = 1'b1;
                mem_wr         = 1'b1;
                memory_address = word_addr(victim_base, issue_cnt);
                mem_wdata      = evict_data;
            end
`endif
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_more) begin
                    mem_enable     = 1'b1;
                    memory_address = word_addr(line_base, issue_cnt);
                end
                if (ret_take) begin
                    write_data_array = 1'b1;
                    fill_word        = ret_cnt[IDX_W-1:0];
                    write_tag_array  = last_ret;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl against a cycle-timeline model.
// Follows CACHE_FILL_WRITEBACK_EN the same way the design does.
module tb_cache_fill_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int N   = 8;
    localparam int BPW = 2;
    localparam logic [AW-1:0] LMASK = 16'h000F;

`ifdef CACHE_FILL_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          victim_dirty;
    logic [AW-1:0] victim_address;
    logic [DW-1:0] evict_data;
    logic          memory_data_valid;
    logic          fsm_busy;
    logic          write_data_array;
    logic          write_tag_array;
    logic [2:0]    fill_word;
    logic          mem_enable;
    logic          mem_wr;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] mem_wdata;

    logic          m2_miss;
    logic [15:0]   m2_addr;
    logic          m2_dirty;
    logic [15:0]   m2_victim;
    logic [31:0]   m2_evict;
    logic          m2_valid;
    logic          b2_busy;
    logic          b2_wda;
    logic          b2_tag;
    logic [1:0]    b2_fw;
    logic          b2_en;
    logic          b2_wr;
    logic [15:0]   b2_addr;
    logic [31:0]   b2_wdata;

    cache_fill_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .victim_dirty      (victim_dirty),
        .victim_address    (victim_address),
        .evict_data        (evict_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word         (fill_word),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .memory_address    (memory_address),
        .mem_wdata         (mem_wdata)
    );

    cache_fill_ctrl #(
        .ADDR_W         (16),
        .DATA_W         (32),
        .WORDS_PER_LINE (4)
    ) dut2 (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (m2_miss),
        .miss_address      (m2_addr),
        .victim_dirty      (m2_dirty),
        .victim_address    (m2_victim),
        .evict_data        (m2_evict),
        .memory_data_valid (m2_valid),
        .fsm_busy          (b2_busy),
        .write_data_array  (b2_wda),
        .write_tag_array   (b2_tag),
        .fill_word         (b2_fw),
        .mem_enable        (b2_en),
        .mem_wr            (b2_wr),
        .memory_address    (b2_addr),
        .mem_wdata         (b2_wdata)
    );

    int total = 0;
    int bad   = 0;
    int fixed_rc[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(fsm_busy), 0);
        check({tag, "_en"}, 32'(mem_enable), 0);
        check({tag, "_wr"}, 32'(mem_wr), 0);
        check({tag, "_wda"}, 32'(write_data_array), 0);
        check({tag, "_tag"}, 32'(write_tag_array), 0);
    endtask

    // One miss. Cycle 0 is the miss cycle; the model derives every output
    // from where cycle t falls on the write / read / return timeline.
    task automatic run_txn(input logic [AW-1:0] addr, input bit dirty,
                           input logic [AW-1:0] victim, input bit hold,
                           input int lat, input int extra, input bit gap);
        logic [AW-1:0] base, vb;
        bit            edirty, is_ret;
        int            r0, fs, prev, c, end_c, k, t;
        int            rc[$];
        base   = addr & ~LMASK;
        vb     = victim & ~LMASK;
        edirty = WB && dirty;
        r0     = edirty ? N + 1 : 0;
        fs     = edirty ? N + 1 : 1;
        if (fixed_rc.size() == N) begin
            rc = fixed_rc;
        end else begin
            prev = -1;
            for (int i = 0; i < N; i++) begin
                c = r0 + i + lat + int'($urandom_range(0, extra));
                if (c <= prev) c = prev + 1;
                if (c < fs) c = fs;
                rc.push_back(c);
                prev = c;
            end
        end
        end_c = rc[N-1];
        k = 0;
        for (t = 0; t <= end_c; t++) begin
            miss_detected  = (t == 0) || hold;
            miss_address   = (t == 0) ? addr : AW'($urandom);
            victim_dirty   = (t == 0) ? dirty : 1'($urandom);
            victim_address = (t == 0) ? victim : AW'($urandom);
            evict_data     = DW'($urandom);
            is_ret = (k < N) && (rc[k] == t);
            memory_data_valid = is_ret || ((t < fs) && ($urandom_range(0, 1) == 1));
            @(negedge clk);
            check("busy", 32'(fsm_busy), 1);
            if (edirty && t >= 1 && t <= N) begin
                check("ev_en", 32'(mem_enable), 1);
                check("ev_wr", 32'(mem_wr), 1);
                check("ev_addr", 32'(memory_address), 32'(vb + AW'((t - 1) * BPW)));
                check("ev_data", 32'(mem_wdata), 32'(evict_data));
                check("ev_word", 32'(fill_word), 32'(t - 1));
            end else if (t >= r0 && t < r0 + N) begin
                check("rd_en", 32'(mem_enable), 1);
                check("rd_wr", 32'(mem_wr), 0);
                check("rd_addr", 32'(memory_address), 32'(base + AW'((t - r0) * BPW)));
            end else begin
                check("no_req", 32'(mem_enable), 0);
            end
            check("wda", 32'(write_data_array), 32'(is_ret));
            if (is_ret) check("fill_word", 32'(fill_word), 32'(k));
            check("tag", 32'(write_tag_array), 32'(is_ret && k == N - 1));
            if (is_ret) k++;
            next_cycle();
        end
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        if (gap) begin
            memory_data_valid = 1'b1;
            @(negedge clk);
            check_quiet("post");
            next_cycle();
            memory_data_valid = 1'b0;
        end
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        victim_dirty      = 1'b0;
        victim_address    = '0;
        evict_data        = '0;
        memory_data_valid = 1'b0;
        m2_miss   = 1'b0;
        m2_addr   = '0;
        m2_dirty  = 1'b0;
        m2_victim = '0;
        m2_evict  = '0;
        m2_valid  = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check_quiet("rst");
        check("rst_word", 32'(fill_word), 0);
        check("rst_addr", 32'(memory_address), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst2_busy", 32'(b2_busy), 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_txn(16'h1236, 1'b0, 16'h0000, 1'b0, 4, 0, 1'b1);
        run_txn(16'h2000, 1'b1, 16'h5A50, 1'b0, 4, 0, 1'b1);

        fixed_rc = '{4, 6, 7, 10, 11, 12, 15, 16};
        run_txn(16'h3458, 1'b0, 16'h0000, 1'b0, 4, 0, 1'b1);
        fixed_rc.delete();

        run_txn(16'h4442, 1'b0, 16'h0000, 1'b1, 3, 2, 1'b1);
        run_txn(16'h4470, 1'b1, 16'h7700, 1'b1, 2, 1, 1'b0);
        run_txn(16'h8882, 1'b0, 16'h0000, 1'b0, 1, 0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            run_txn(AW'($urandom), 1'($urandom),
                    AW'($urandom) & ~LMASK, 1'($urandom),
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        // reset lands in cycle 5 of a fill; later stray returns are ignored
        for (int t = 0; t < 5; t++) begin
            miss_detected = (t == 0);
            miss_address  = 16'h9AB4;
            victim_dirty  = 1'b0;
            next_cycle();
        end
        miss_detected = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        memory_data_valid = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid");
        next_cycle();
        for (int t = 0; t < 4; t++) begin
            memory_data_valid = 1'b1;
            @(negedge clk);
            check_quiet("late_ret");
            next_cycle();
        end
        memory_data_valid = 1'b0;

        // four-word line of 32-bit words on the second instance
        for (int t = 0; t <= 8; t++) begin
            m2_miss  = (t == 0);
            m2_addr  = 16'h00F4;
            m2_valid = (t >= 4 && t <= 7);
            @(negedge clk);
            check("w4_busy", 32'(b2_busy), 32'(t <= 7));
            check("w4_en", 32'(b2_en), 32'(t < 4));
            if (t < 4) check("w4_addr", 32'(b2_addr), 32'(16'h00F0 + 16'(t * 4)));
            check("w4_wr", 32'(b2_wr), 0);
            check("w4_wda", 32'(b2_wda), 32'(t >= 4 && t <= 7));
            if (t >= 4 && t <= 7) check("w4_word", 32'(b2_fw), 32'(t - 4));
            check("w4_tag", 32'(b2_tag), 32'(t == 7));
            next_cycle();
        end
        m2_miss  = 1'b0;
        m2_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
